// File: rtl/uncache_ctrl_pkg.sv
// Shared CPU defines for the uncached access controller:
// FSM state encoding and fixed AXI encodings.
package uncache_ctrl_pkg;

    typedef enum logic [2:0] {
        UNC_IDLE,
        UNC_RD_AR,
        UNC_RD_R,
        UNC_WR_AW_W,
        UNC_WR_B,
        UNC_DONE
    } unc_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    // Access size 0/1/2 maps directly onto AXI 1/2/4-byte size codes.
    function automatic logic [2:0] axi_size(input logic [1:0] s);
        return {1'b0, s};
    endfunction

endpackage

// File: rtl/uncache_ctrl.sv
// Uncached load/store controller: turns one MEM-stage access
// into a single-beat AXI read or write and stalls until done.
module uncache_ctrl
    import uncache_ctrl_pkg::*;
#(
    parameter int AXI_ID_W = 4,
    parameter int UNC_ID   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_op,
    input  logic [31:0]         req_paddr,
    input  logic [1:0]          req_size,
    input  logic [3:0]          req_wstrb,
    input  logic [31:0]         req_wdata,
    input  logic                req_flush,
    input  logic                pipe_adv,
    output logic                busy,
    output logic                rdata_valid,
    output logic [31:0]         rdata,
    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [31:0]         rdata_axi,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [AXI_ID_W-1:0] awid,
    output logic [31:0]         awaddr,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         wdata,
    output logic [3:0]          wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic                bvalid,
    output logic                bready
);

    unc_state_t  r_state;
    unc_state_t  w_next;
    logic        r_kill;
    logic        r_op;
    logic        r_aw_done;
    logic        r_w_done;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_kill;
    logic        w_outst;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_unused;

    // Single-beat reads always end on the first beat.
    assign w_unused = rlast;

    assign w_accept = req_valid & ~req_flush;
    assign w_kill   = r_kill | req_flush;
    assign w_outst  = (r_state == UNC_RD_AR) | (r_state == UNC_RD_R)
                    | (r_state == UNC_WR_AW_W) | (r_state == UNC_WR_B);
    assign w_aw_hs  = awvalid & awready;
    assign w_w_hs   = wvalid & wready;

    assign arid    = AXI_ID_W'(UNC_ID);
    assign araddr  = r_addr;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = axi_size(r_size);
    assign arburst = AXI_BURST_INCR;
    assign awid    = AXI_ID_W'(UNC_ID);
    assign awaddr  = r_addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = axi_size(r_size);
    assign awburst = AXI_BURST_INCR;
    assign wdata   = r_wdata;
    assign wstrb   = r_strb;
    assign wlast   = 1'b1;
    assign rdata   = r_rdata;

    // Next-state, channel valids/readies and stall request.
    always_comb begin
        w_next      = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        rdata_valid = 1'b0;
        busy        = w_kill ? req_valid : 1'b1;
        unique case (r_state)
            UNC_IDLE: begin
                busy = w_accept;
                if (w_accept) begin
                    w_next = req_op ? UNC_WR_AW_W : UNC_RD_AR;
                end
            end
            UNC_RD_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    w_next = UNC_RD_R;
                end
            end
            UNC_RD_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    w_next = w_kill ? UNC_IDLE : UNC_DONE;
                end
            end
            UNC_WR_AW_W: begin
                awvalid = ~r_aw_done;
                wvalid  = ~r_w_done;
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_next = UNC_WR_B;
                end
            end
            UNC_WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    w_next = w_kill ? UNC_IDLE : UNC_DONE;
                end
            end
            UNC_DONE: begin
                busy        = 1'b0;
                rdata_valid = ~r_op;
                if (req_flush | pipe_adv) begin
                    w_next = UNC_IDLE;
                end
            end
            default: begin
                w_next = UNC_IDLE;
            end
        endcase
    end

    // State, kill flag, latched request and captured read word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= UNC_IDLE;
            r_kill    <= 1'b0;
            r_op      <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_size    <= '0;
            r_strb    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == UNC_IDLE) && w_accept) begin
                r_op      <= req_op;
                r_addr    <= req_paddr;
                r_size    <= req_size;
                r_strb    <= req_wstrb;
                r_wdata   <= req_wdata;
                r_kill    <= 1'b0;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_outst && req_flush) begin
                r_kill <= 1'b1;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (rready && rvalid) begin
                r_rdata <= rdata_axi;
            end
        end
    end

endmodule

// File: tb/tb_uncache_ctrl.sv
// Bench for uncache_ctrl: vector table of single accesses
// served by a delay-programmable AXI slave plus corner cases.
module tb_uncache_ctrl;

    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_op = 1'b0;
    logic [31:0]    req_paddr = '0;
    logic [1:0]     req_size = '0;
    logic [3:0]     req_wstrb = '0;
    logic [31:0]    req_wdata = '0;
    logic           req_flush = 1'b0;
    logic           pipe_adv = 1'b0;
    logic           busy;
    logic           rdata_valid;
    logic [31:0]    rdata;
    logic [IDW-1:0] arid;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid;
    logic           arready = 1'b0;
    logic [31:0]    rdata_axi = '0;
    logic           rlast = 1'b0;
    logic           rvalid = 1'b0;
    logic           rready;
    logic [IDW-1:0] awid;
    logic [31:0]    awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic           awvalid;
    logic           awready = 1'b0;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready = 1'b0;
    logic           bvalid = 1'b0;
    logic           bready;

    uncache_ctrl #(.AXI_ID_W(IDW), .UNC_ID(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op),
        .req_paddr(req_paddr), .req_size(req_size),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .req_flush(req_flush), .pipe_adv(pipe_adv),
        .busy(busy), .rdata_valid(rdata_valid), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata_axi(rdata_axi), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rword;
        int          ard;
        int          rd;
        int          awd;
        int          wd;
        int          bd;
    } vec_t;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rword;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur;
    int   nchecks = 0;
    int   nerrors = 0;
    int   n_ar = 0;
    int   n_aw = 0;
    int   cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc_cnt);
        end
    endtask

    task automatic take_cur();
        if (!have_cur) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) cur = exp_q.pop_front();
            have_cur = 1;
        end
    endtask

    // mode: 0 normal, 1 flush in RD_R, 2 stop in WR_B, 3 flush in DONE
    task automatic slave(input vec_t v, input int mode, output bit ok);
        int c_ar = 0, c_r = 0, c_aw = 0, c_w = 0, c_b = 0;
        bit ar_hs = 0, aw_hs = 0, w_hs = 0, fin = 0, flushed = 0;
        bit p_ar = 0, p_aw = 0, p_w = 0;
        logic [31:0] s_ar = '0, s_aw = '0, s_w = '0;
        ok = 0;
        have_cur = 0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            arready = arvalid && (c_ar >= v.ard);
            if (arvalid && !arready) c_ar++;
            rvalid = ar_hs && (c_r >= v.rd);
            if (ar_hs && !rvalid) c_r++;
            rdata_axi = rvalid ? v.rword : $urandom;
            rlast = rvalid;
            awready = awvalid && (c_aw >= v.awd);
            if (awvalid && !awready) c_aw++;
            wready = wvalid && (c_w >= v.wd);
            if (wvalid && !wready) c_w++;
            bvalid = aw_hs && w_hs && (c_b >= v.bd);
            if (aw_hs && w_hs && !bvalid) c_b++;
            req_flush = 0;
            if (mode == 1 && rready && !flushed) begin
                req_flush = 1;
                req_valid = 0;
                flushed = 1;
            end
            if (mode == 2 && bready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            if (flushed) check("busy_killed", busy, req_valid);
            if (p_ar) begin
                check("ar_held", arvalid, 1);
                check("ar_stable", araddr, s_ar);
            end
            if (p_aw) begin
                check("aw_held", awvalid, 1);
                check("aw_stable", awaddr, s_aw);
            end
            if (p_w) begin
                check("w_held", wvalid, 1);
                check("w_stable", wdata, s_w);
            end
            p_ar = arvalid && !arready;
            s_ar = araddr;
            p_aw = awvalid && !awready;
            s_aw = awaddr;
            p_w = wvalid && !wready;
            s_w = wdata;
            if (arvalid && arready) begin
                ar_hs = 1;
                n_ar++;
                take_cur();
                check("ar_is_load", cur.op, 0);
                check("araddr", araddr, cur.addr);
                check("arsize", arsize, cur.size);
                check("arlen", arlen, 0);
                check("arburst", arburst, 1);
                check("arid", arid, 1);
            end
            if (awvalid && awready) begin
                aw_hs = 1;
                n_aw++;
                take_cur();
                check("aw_is_store", cur.op, 1);
                check("awaddr", awaddr, cur.addr);
                check("awsize", awsize, cur.size);
                check("awlen", awlen, 0);
                check("awburst", awburst, 1);
                check("awid", awid, 1);
            end
            if (wvalid && wready) begin
                w_hs = 1;
                take_cur();
                check("wdata", wdata, cur.wdata);
                check("wstrb", wstrb, cur.strb);
                check("wlast", wlast, 1);
            end
            if ((rvalid && rready) || (bvalid && bready)) fin = 1;
            @(posedge clk);
            #1;
        end
        arready = 0;
        rvalid = 0;
        rlast = 0;
        awready = 0;
        wready = 0;
        bvalid = 0;
        req_flush = 0;
        rdata_axi = $urandom;
        if (mode != 2) ok = fin;
        check("slave_done", ok, 1);
    endtask

    task automatic run_vec(input vec_t v, input int mode, input bit chk_lat);
        exp_t e;
        bit ok;
        int c0, nar0, naw0;
        e.op = v.op;
        e.addr = v.addr;
        e.size = {1'b0, v.size};
        e.strb = v.strb;
        e.wdata = v.wdata;
        e.rword = v.rword;
        exp_q.push_back(e);
        req_op = v.op;
        req_paddr = v.addr;
        req_size = v.size;
        req_wstrb = v.strb;
        req_wdata = v.wdata;
        req_valid = 1;
        req_flush = 0;
        pipe_adv = 0;
        c0 = cyc_cnt;
        nar0 = n_ar;
        naw0 = n_aw;
        @(negedge clk);
        check("busy_on_req", busy, 1);
        @(posedge clk);
        #1;
        req_paddr = ~v.addr;
        req_size = ~v.size;
        req_wstrb = ~v.strb;
        req_wdata = ~v.wdata;
        slave(v, mode, ok);
        if (chk_lat) check("load_latency", cyc_cnt - c0, 3);
        if (mode == 2) return;
        if (mode == 1) begin
            @(negedge clk);
            check("kill_busy", busy, 0);
            check("kill_no_rdv", rdata_valid, 0);
            check("kill_no_ar", arvalid, 0);
            check("kill_rready", rready, 0);
            check("kill_one_ar", n_ar - nar0, 1);
            @(posedge clk);
            #1;
            return;
        end
        for (int h = 0; h < 4; h++) begin
            @(negedge clk);
            check("done_busy", busy, 0);
            check("done_rdv", rdata_valid, !v.op);
            if (!v.op) check("done_rdata", rdata, cur.rword);
            check("done_no_ar", arvalid, 0);
            check("done_no_aw", awvalid, 0);
            @(posedge clk);
            #1;
        end
        check("one_ar", n_ar - nar0, v.op ? 0 : 1);
        check("one_aw", n_aw - naw0, v.op ? 1 : 0);
        if (mode == 3) begin
            req_flush = 1;
        end else begin
            pipe_adv = 1;
            req_valid = 0;
        end
        @(posedge clk);
        #1;
        pipe_adv = 0;
        req_flush = 0;
        req_valid = 0;
        @(negedge clk);
        check("adv_rdv_clr", rdata_valid, 0);
        check("adv_busy", busy, 0);
        check("adv_no_ar", arvalid, 0);
        check("adv_no_aw", awvalid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[6];
        vec_t vk;
        vt[0] = '{op:0, addr:32'h1FAF_F000, size:2, strb:0, wdata:0,
                  rword:32'hDEAD_BEEF, ard:0, rd:0, awd:0, wd:0, bd:0};
        vt[1] = '{op:1, addr:32'h1FAF_F002, size:1, strb:4'hC,
                  wdata:32'h1234_0000, rword:0,
                  ard:0, rd:0, awd:0, wd:3, bd:2};
        vt[2] = '{op:0, addr:32'h1FD0_0001, size:0, strb:0, wdata:0,
                  rword:32'h0000_5A00, ard:2, rd:1, awd:0, wd:0, bd:0};
        vt[3] = '{op:1, addr:32'hBFC0_0004, size:2, strb:4'hF,
                  wdata:32'hCAFE_F00D, rword:0,
                  ard:0, rd:0, awd:2, wd:0, bd:0};
        vt[4] = '{op:1, addr:32'h1FAF_0003, size:0, strb:4'h8,
                  wdata:32'hAB00_0000, rword:0,
                  ard:0, rd:0, awd:1, wd:1, bd:1};
        vt[5] = '{op:0, addr:32'h1FAF_0006, size:1, strb:0, wdata:0,
                  rword:32'h1234_5678, ard:0, rd:3, awd:0, wd:0, bd:0};

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rdv", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_bready", bready, 0);
        @(posedge clk);
        #1;
        rst = 0;

        req_valid = 1;
        req_flush = 1;
        req_op = 0;
        @(negedge clk);
        check("idle_flush_busy", busy, 0);
        @(posedge clk);
        #1;
        req_valid = 0;
        req_flush = 0;
        @(negedge clk);
        check("idle_flush_no_ar", arvalid, 0);
        check("idle_flush_no_aw", awvalid, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(vt[i], 0, i == 0);

        vk = vt[0];
        vk.addr = 32'h1FAF_F010;
        vk.rword = 32'h5555_AAAA;
        vk.rd = 5;
        run_vec(vk, 1, 0);
        run_vec(vt[0], 0, 1);

        run_vec(vt[2], 3, 0);

        vk = vt[1];
        vk.bd = 10;
        run_vec(vk, 2, 0);
        rst = 1;
        req_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("wb_rst_arvalid", arvalid, 0);
        check("wb_rst_awvalid", awvalid, 0);
        check("wb_rst_wvalid", wvalid, 0);
        check("wb_rst_bready", bready, 0);
        check("wb_rst_rready", rready, 0);
        check("wb_rst_busy", busy, 0);
        check("wb_rst_rdv", rdata_valid, 0);
        check("wb_rst_rdata", rdata, 0);
        @(posedge clk);
        #1;

        run_vec(vt[3], 0, 0);
        run_vec(vt[5], 0, 0);
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uncache_ctrl.md
UNCACHE_CTRL -- requirements
Module: uncache_ctrl

Interface
REQ-001 SHALL have parameter AXI_ID_W, default 4: width of arid/awid.
REQ-002 SHALL have parameter UNC_ID, default 1: constant ID on every AR/AW.
REQ-003 SHALL have ports (name  direction  width  meaning); reset polarity and synchronicity fixed (one clock, synchronous active-high reset):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  MEM-stage uncached access present
- req_op  in  1  0 = load, 1 = store
- req_paddr  in  32  physical address
- req_size  in  2  0 = byte, 1 = half, 2 = word
- req_wstrb  in  4  store byte enables
- req_wdata  in  32  store data, lane-aligned
- req_flush  in  1  MEM_Flush; kills the current instruction
- pipe_adv  in  1  MEM_Wr; the held instruction leaves the stage
- busy  out  1  stall request to hazard unit
- rdata_valid  out  1  load data ready
- rdata  out  32  raw bus word
- AR outputs: arid[AXI_ID_W], araddr[32], arlen[8], arsize[3], arburst[2], arvalid; AR input: arready
- R inputs: rdata_axi[32], rlast, rvalid; R output: rready
- AW outputs: awid, awaddr[32], awlen, awsize, awburst, awvalid; AW input: awready
- W outputs: wdata[32], wstrb[4], wlast, wvalid; W input: wready
- B input: bvalid; B output: bready

Function
REQ-004 SHALL use states IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
REQ-005 IDLE: req_valid=1 and req_flush=0 -> latch paddr/size/wstrb/wdata; go to RD_AR (op=0) or WR_AW_W (op=1) next cycle.
REQ-006 RD_AR: arvalid=1; on arvalid&arready -> RD_R.
REQ-007 RD_R: rready=1; on rvalid -> capture rdata_axi into rdata; go to DONE.
REQ-008 WR_AW_W: awvalid and wvalid both raised on entry, each dropping independently after its own handshake; both done (same or different cycles) -> WR_B.
REQ-009 WR_B: bready=1; on bvalid -> DONE.
REQ-010 DONE: busy=0 and rdata_valid=1 (loads only); state and rdata held until pipe_adv=1, then IDLE; no re-issue while the same request is held.
REQ-011 busy = req_valid & ~req_flush in IDLE; 1 in RD_AR/RD_R/WR_AW_W/WR_B; 0 in DONE.
REQ-012 SHALL fix arlen=awlen=0, arburst=awburst=INCR, wlast=1, ax size = {0,req_size}, addresses = latched paddr unmodified; rresp/bresp ignored.
REQ-013 AXI valid signals SHALL NOT drop before handshake, and payloads SHALL be stable while valid.
REQ-014 req_flush while outstanding: transaction SHALL complete on AXI; kill flag set; on completion go to IDLE, not DONE; no rdata_valid.
REQ-015 While killed and outstanding, busy SHALL equal req_valid, so non-memory instructions are not stalled.
REQ-016 req_flush in DONE -> IDLE next cycle, rdata_valid cleared.
REQ-017 Minimum load latency SHALL be accept -> 1 cycle AR -> R -> DONE (3 cycles to busy=0 with zero-wait slave).

Reset
REQ-018 rst=1 SHALL force IDLE, kill=0, all AXI valids/readies 0, busy=0, rdata_valid=0, rdata=0 on the next edge; reset mid-transaction abandons it (system reset implies slave reset).

Structure
REQ-019 State enum and size/burst encodings SHALL live in the shared CPU defines package; AXI channel signals SHALL be grouped through the existing AXI_UNCACHE_Interface modport.
REQ-020 Single module, no sub-modules.

Verification
REQ-021 Load, paddr=0x1FAF_F000, size=2, slave arready=1, rvalid one cycle later with 0xDEAD_BEEF -> araddr=0x1FAF_F000, arsize=2, rdata=0xDEAD_BEEF, rdata_valid in DONE, busy=0 from DONE.
REQ-022 Store, paddr=0x1FAF_F002, size=1, wstrb=0xC, wdata=0x1234_0000, awready 3 cycles before wready, bvalid 2 cycles later -> awsize=1, wstrb=0xC, both valids held until their handshakes, busy drops on DONE.
REQ-023 pipe_adv=0 for 4 cycles in DONE with req_valid=1 -> exactly one AR observed, rdata stable.
REQ-024 req_flush asserted in RD_R, rvalid 5 cycles later -> R accepted, no rdata_valid, IDLE afterwards, busy=0 with req_valid=0.
REQ-025 rst asserted in WR_B -> next cycle all valids 0, IDLE, busy=0.
